rdma_rc_pdu_tx: RTL and testbench
=================================

// Module: rdma_rc_pdu_tx
// PURPOSE
//  Transmit-side counterpart of the RC PDU receive parser. Accepts TX requests, checks the opcode class against QP state,
//  builds a 64-bit header beat, streams N payload beats and owns the 24-bit send-PSN counter.
//  Sits between the QP state machine / send engine and the physical-layer TX interface.
//  Header layout matches the receive path: opcode[63:56], rsvd 0 [55:48], QPN[47:32], PSN[31:8], rsvd 0 [7:4], beat count [3:0].
// PARAMETERS
//  QPN_WIDTH     16  QP number width; must equal 16 for the header layout.
//  PSN_WIDTH     24  PSN width; counter wraps modulo 2^PSN_WIDTH.
//  OPCODE_WIDTH  8   opcode width.
//  DATA_WIDTH    64  PDU bus width; header occupies bits [63:0], upper bits zero.
//  LEN_WIDTH     4   payload beat-count width (0..15 beats).
// PORTS
//  clk           in   1           system clock
//  rst           in   1           asynchronous reset, active-high
//  qp_state      in   3           QP state: RESET=0, INIT=1, RTR=2, RTS=3, ERROR=7
//  remote_qpn    in   QPN_WIDTH   destination QPN placed in header
//  psn_load      in   1           load send PSN from psn_init
//  psn_init      in   PSN_WIDTH   initial send PSN
//  req_valid     in   1           TX request valid
//  req_ready     out  1           request accepted when valid&ready
//  req_opcode    in   8           requested opcode
//  req_len       in   LEN_WIDTH   payload beats following header
//  pl_data       in   DATA_WIDTH  payload beat
//  pl_valid      in   1           payload beat valid
//  pl_ready      out  1           payload beat taken when valid&ready
//  pdu_data      out  DATA_WIDTH  TX beat (header or payload)
//  pdu_valid     out  1           TX beat valid; held stable until pdu_ready
//  pdu_ready     in   1           downstream accepts beat
//  pdu_sop       out  1           current beat is header
//  pdu_eop       out  1           current beat is last beat of PDU
//  req_reject    out  1           1-cycle pulse: request dropped (state/opcode mismatch)
//  send_psn      out  PSN_WIDTH   next PSN to be used
// BEHAVIOUR
//  Reset: state IDLE; req_ready=0 during reset then 1; pl_ready=0; pdu_valid/sop/eop=0; pdu_data=0; req_reject=0; send_psn=0.
//  FSM IDLE->HDR->PAYLOAD->IDLE. req_ready=1 only in IDLE with no beat pending.
//  Accept check on qp_state sampled at accept: RTS allows 0x00-0x1F (data); RTR allows 0x20-0x7F (control).
//   Any other state/opcode combo, or opcode>=0x80: req_reject pulses next cycle, nothing emitted, stay IDLE.
//  Legal accept at cycle N: header on pdu_data with pdu_valid=1, pdu_sop=1 at N+1; pdu_eop=1 on header if req_len=0.
//  PSN field = send_psn at accept. Data-frame header handshake increments send_psn by 1 (0xFFFFFF->0); control frames do not.
//  HDR: after header handshake go PAYLOAD (len>0) or IDLE (len=0).
//  PAYLOAD: pl_ready = !pdu_valid || pdu_ready; taken beat appears on pdu_data next cycle; eop on beat #len; beat count
//   reaches len -> IDLE after final handshake. Back-to-back PDUs: next header no earlier than 1 cycle after final handshake.
//  Backpressure: pdu_valid/data/sop/eop never change while pdu_valid=1 && pdu_ready=0.
//  qp_state changes after accept do not affect an in-flight PDU; it completes.
//  psn_load: any cycle; beats an increment in the same cycle (loaded value wins); in-flight header keeps old PSN.
//  rst mid-PDU: PDU truncated, all outputs to reset values immediately, PSN=0.
// CONFIGURATION
//  RDMA_PDU_TX_STATS_EN defined: adds outputs stat_tx_pdus[31:0] (++ on each eop handshake) and stat_tx_rejects[15:0]
//   (++ per req_reject); both saturate, cleared by rst. Undefined: ports and counters absent, behaviour otherwise identical.
// TESTING
//  rst release, psn_load 0x000010, qp_state=RTS, req opcode 0x04 len 2 -> hdr 0x0400_<QPN>_000010_02, 2 beats, eop on 2nd, send_psn=0x000011.
//  qp_state=RTR, req opcode 0x30 len 0 -> single beat sop=eop=1, PSN unchanged.
//  qp_state=RTS, req opcode 0x30; qp_state=INIT opcode 0x04; opcode 0x85 -> req_reject each, no pdu_valid.
//  psn_load 0xFFFFFF, RTS data PDU -> header PSN 0xFFFFFF, send_psn wraps to 0x000000.
//  pdu_ready held 0 for 5 cycles mid-payload -> pdu_data stable, pl_ready=0, no beat lost or duplicated.
//  rst asserted during beat 1 of 3 -> pdu_valid=0 at once, next request emits header with PSN 0.

Source files
------------

// File: rtl/rdma_rc_pdu_tx.sv
// RC PDU transmit builder: checks opcode class vs QP state, emits header beat + N payload beats, owns send PSN.
// Latency: header valid 1 cycle after request accept; each payload beat appears 1 cycle after it is taken.
// Backpressure: output beat held stable while pdu_ready=0; pl_ready/req_ready deasserted until the beat drains.
// Optional statistics counters enabled by defining RDMA_PDU_TX_STATS_EN.
module rdma_rc_pdu_tx #(
  parameter int QPN_WIDTH    = 16,
  parameter int PSN_WIDTH    = 24,
  parameter int OPCODE_WIDTH = 8,
  parameter int DATA_WIDTH   = 64,
  parameter int LEN_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              qp_state,
  input  logic [QPN_WIDTH-1:0]    remote_qpn,
  input  logic                    psn_load,
  input  logic [PSN_WIDTH-1:0]    psn_init,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [OPCODE_WIDTH-1:0] req_opcode,
  input  logic [LEN_WIDTH-1:0]    req_len,
  input  logic [DATA_WIDTH-1:0]   pl_data,
  input  logic                    pl_valid,
  output logic                    pl_ready,
  output logic [DATA_WIDTH-1:0]   pdu_data,
  output logic                    pdu_valid,
  input  logic                    pdu_ready,
  output logic                    pdu_sop,
  output logic                    pdu_eop,
  output logic                    req_reject,
  output logic [PSN_WIDTH-1:0]    send_psn
`ifdef RDMA_PDU_TX_STATS_EN
  ,
  output logic [31:0]             stat_tx_pdus,
  output logic [15:0]             stat_tx_rejects
`endif
);

  localparam logic [2:0] QP_RTR = 3'd2;
  localparam logic [2:0] QP_RTS = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD} state_t;

  state_t                  state, state_nxt;
  logic [LEN_WIDTH-1:0]    len_q, cnt_q, cnt_inc;
  logic                    is_data_q;
  logic                    is_data_req, legal, accept, hs, take;
  logic [DATA_WIDTH-1:0]   hdr;
  logic [PSN_WIDTH-1:0]    psn_inc;

  // Opcode class check against the QP state seen at accept, plus header assembly.
  always_comb begin
    is_data_req = (req_opcode < OPCODE_WIDTH'(32));
    legal       = !req_opcode[OPCODE_WIDTH-1] &&
                  (((qp_state == QP_RTS) && is_data_req) ||
                   ((qp_state == QP_RTR) && !is_data_req));
    hdr         = '0;
    hdr[63:0]   = {req_opcode, 8'h00, remote_qpn, send_psn, 4'h0, req_len};
    accept      = req_valid && req_ready;
    hs          = pdu_valid && pdu_ready;
    take        = pl_valid && pl_ready;
    cnt_inc     = cnt_q + 1'b1;
    psn_inc     = send_psn + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state and handshake readies; payload intake stops once len beats are taken.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    pl_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = !rst && !pdu_valid;
        if (req_valid && req_ready && legal) state_nxt = S_HDR;
      end
      S_HDR: begin
        if (hs) state_nxt = (len_q == '0) ? S_IDLE : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        pl_ready = (!pdu_valid || pdu_ready) && (cnt_q != len_q);
        if (hs && pdu_eop) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output beat register: loads header on accept, payload on take, drops valid on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pdu_data   <= '0;
      pdu_valid  <= 1'b0;
      pdu_sop    <= 1'b0;
      pdu_eop    <= 1'b0;
      req_reject <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      is_data_q  <= 1'b0;
    end else begin
      req_reject <= accept && !legal;
      case (state)
        S_IDLE: begin
          if (accept && legal) begin
            pdu_data  <= hdr;
            pdu_valid <= 1'b1;
            pdu_sop   <= 1'b1;
            pdu_eop   <= (req_len == '0);
            len_q     <= req_len;
            cnt_q     <= '0;
            is_data_q <= is_data_req;
          end
        end
        S_HDR: begin
          if (hs) begin
            pdu_valid <= 1'b0;
            pdu_sop   <= 1'b0;
            pdu_eop   <= 1'b0;
          end
        end
        S_PAYLOAD: begin
          if (take) begin
            pdu_data  <= pl_data;
            pdu_valid <= 1'b1;
            pdu_sop   <= 1'b0;
            pdu_eop   <= (cnt_inc == len_q);
            cnt_q     <= cnt_inc;
          end else if (hs) begin
            pdu_valid <= 1'b0;
            pdu_eop   <= 1'b0;
          end
        end
        default: pdu_valid <= 1'b0;
      endcase
    end
  end

  // Send PSN: explicit load wins over the data-header increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    send_psn <= '0;
    else if (psn_load)                          send_psn <= psn_init;
    else if (state == S_HDR && hs && is_data_q) send_psn <= psn_inc;
  end

`ifdef RDMA_PDU_TX_STATS_EN
  // Saturating PDU and reject counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_tx_pdus    <= '0;
      stat_tx_rejects <= '0;
    end else begin
      if (hs && pdu_eop && stat_tx_pdus != 32'hFFFF_FFFF) stat_tx_pdus <= stat_tx_pdus + 1'b1;
      if (req_reject && stat_tx_rejects != 16'hFFFF)      stat_tx_rejects <= stat_tx_rejects + 1'b1;
    end
  end
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_rdma_rc_pdu_tx.sv
// Directed bench for rdma_rc_pdu_tx: header format, PSN handling, rejects, backpressure, reset mid-PDU.
module tb_rdma_rc_pdu_tx;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  qp_state;
  logic [15:0] remote_qpn;
  logic        psn_load;
  logic [23:0] psn_init;
  logic        req_valid, req_ready;
  logic [7:0]  req_opcode;
  logic [3:0]  req_len;
  logic [63:0] pl_data;
  logic        pl_valid, pl_ready;
  logic [63:0] pdu_data;
  logic        pdu_valid, pdu_ready, pdu_sop, pdu_eop;
  logic        req_reject;
  logic [23:0] send_psn;
`ifdef RDMA_PDU_TX_STATS_EN
  logic [31:0] stat_tx_pdus;
  logic [15:0] stat_tx_rejects;
`endif

  int tests = 0;
  int fails = 0;

  rdma_rc_pdu_tx dut (
    .clk(clk), .rst(rst), .qp_state(qp_state), .remote_qpn(remote_qpn),
    .psn_load(psn_load), .psn_init(psn_init),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode), .req_len(req_len),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .pdu_data(pdu_data), .pdu_valid(pdu_valid), .pdu_ready(pdu_ready),
    .pdu_sop(pdu_sop), .pdu_eop(pdu_eop), .req_reject(req_reject), .send_psn(send_psn)
`ifdef RDMA_PDU_TX_STATS_EN
    , .stat_tx_pdus(stat_tx_pdus), .stat_tx_rejects(stat_tx_rejects)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [2:0] rj_state [3];
    logic [7:0] rj_op    [3];
    rj_state[0] = 3'd3; rj_op[0] = 8'h30;
    rj_state[1] = 3'd1; rj_op[1] = 8'h04;
    rj_state[2] = 3'd3; rj_op[2] = 8'h85;

    rst = 1'b1; qp_state = 3'd0; remote_qpn = 16'h1234; psn_load = 1'b0; psn_init = '0;
    req_valid = 1'b0; req_opcode = '0; req_len = '0; pl_data = '0; pl_valid = 1'b0; pdu_ready = 1'b1;
    tick(); tick();
    // Reset state
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_pdu_valid", {63'd0, pdu_valid}, 64'd0);
    chk("rst_pl_ready",  {63'd0, pl_ready}, 64'd0);
    chk("rst_pdu_data",  pdu_data, 64'd0);
    chk("rst_send_psn",  {40'd0, send_psn}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

    // Data PDU, 2 payload beats, PSN 0x10
    psn_load = 1'b1; psn_init = 24'h000010;
    tick();
    psn_load = 1'b0;
    chk("psn_loaded", {40'd0, send_psn}, 64'h10);
    qp_state = 3'd3; req_valid = 1'b1; req_opcode = 8'h04; req_len = 4'd2;
    tick();
    req_valid = 1'b0;
    chk("t1_hdr", pdu_data, 64'h04001234_00001002);
    chk("t1_hdr_flags", {61'd0, pdu_valid, pdu_sop, pdu_eop}, 64'b110);
    pl_valid = 1'b1; pl_data = 64'hAAAA_0000_0000_0001;
    tick();
    chk("t1_psn_inc", {40'd0, send_psn}, 64'h11);
    chk("t1_pl_ready", {63'd0, pl_ready}, 64'd1);
    tick();
    chk("t1_beat1", pdu_data, 64'hAAAA_0000_0000_0001);
    chk("t1_beat1_flags", {61'd0, pdu_valid, pdu_sop, pdu_eop}, 64'b100);
    pl_data = 64'hAAAA_0000_0000_0002;
    tick();
    pl_valid = 1'b0;
    chk("t1_beat2", pdu_data, 64'hAAAA_0000_0000_0002);
    chk("t1_beat2_flags", {61'd0, pdu_valid, pdu_sop, pdu_eop}, 64'b101);
    tick();
    chk("t1_done_valid", {63'd0, pdu_valid}, 64'd0);
    chk("t1_done_ready", {63'd0, req_ready}, 64'd1);

    // Control PDU in RTR, no payload
    qp_state = 3'd2; req_valid = 1'b1; req_opcode = 8'h30; req_len = 4'd0;
    tick();
    req_valid = 1'b0;
    chk("t2_hdr", pdu_data, 64'h30001234_00001100);
    chk("t2_flags", {61'd0, pdu_valid, pdu_sop, pdu_eop}, 64'b111);
    tick();
    chk("t2_valid_off", {63'd0, pdu_valid}, 64'd0);
    chk("t2_psn_same", {40'd0, send_psn}, 64'h11);

    // Rejected requests
    for (int i = 0; i < 3; i++) begin
      qp_state = rj_state[i]; req_valid = 1'b1; req_opcode = rj_op[i]; req_len = 4'd1;
      tick();
      req_valid = 1'b0;
      chk($sformatf("rej%0d_pulse", i), {63'd0, req_reject}, 64'd1);
      chk($sformatf("rej%0d_no_pdu", i), {63'd0, pdu_valid}, 64'd0);
      tick();
      chk($sformatf("rej%0d_pulse_end", i), {62'd0, req_reject, pdu_valid}, 64'd0);
    end
    chk("rej_psn_same", {40'd0, send_psn}, 64'h11);

    // PSN wrap
    psn_load = 1'b1; psn_init = 24'hFFFFFF;
    tick();
    psn_load = 1'b0;
    qp_state = 3'd3; req_valid = 1'b1; req_opcode = 8'h01; req_len = 4'd0;
    tick();
    req_valid = 1'b0;
    chk("t4_hdr", pdu_data, 64'h01001234_FFFFFF00);
    tick();
    chk("t4_psn_wrap", {40'd0, send_psn}, 64'h0);

    // Backpressure mid-payload
    req_valid = 1'b1; req_opcode = 8'h02; req_len = 4'd3;
    tick();
    req_valid = 1'b0;
    chk("t5_hdr", pdu_data, 64'h02001234_00000003);
    pl_valid = 1'b1; pl_data = 64'hC1;
    tick();
    tick();
    chk("t5_beat1", pdu_data, 64'hC1);
    pdu_ready = 1'b0; pl_data = 64'hC2;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t5_bp%0d_data", i), pdu_data, 64'hC1);
      chk($sformatf("t5_bp%0d_flags", i), {61'd0, pdu_valid, pl_ready, pdu_eop}, 64'b100);
      tick();
    end
    pdu_ready = 1'b1;
    tick();
    chk("t5_beat2", pdu_data, 64'hC2);
    pl_data = 64'hC3;
    tick();
    pl_valid = 1'b0;
    chk("t5_beat3", pdu_data, 64'hC3);
    chk("t5_beat3_eop", {62'd0, pdu_valid, pdu_eop}, 64'b11);
    tick();
    chk("t5_done", {63'd0, pdu_valid}, 64'd0);
    chk("t5_psn", {40'd0, send_psn}, 64'h1);

    // Reset during beat 1 of 3
    req_valid = 1'b1; req_opcode = 8'h03; req_len = 4'd3;
    tick();
    req_valid = 1'b0;
    chk("t6_hdr", pdu_data, 64'h03001234_00000103);
    pl_valid = 1'b1; pl_data = 64'hD1;
    tick();
    tick();
    chk("t6_beat1", {63'd0, pdu_valid}, 64'd1);
    rst = 1'b1; pl_valid = 1'b0;
    #1;
    chk("t6_rst_valid", {63'd0, pdu_valid}, 64'd0);
    chk("t6_rst_psn", {40'd0, send_psn}, 64'd0);
    tick();
    rst = 1'b0;
    req_valid = 1'b1; req_opcode = 8'h04; req_len = 4'd0;
    tick();
    req_valid = 1'b0;
    chk("t6_hdr_psn0", pdu_data, 64'h04001234_00000000);
    // Load collides with the data-header increment: load wins
    psn_load = 1'b1; psn_init = 24'h000055;
    tick();
    psn_load = 1'b0;
    chk("t6_load_wins", {40'd0, send_psn}, 64'h55);
    chk("t6_done", {63'd0, pdu_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
